uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter that serialises bytes onto `tx` at a rate set by an external oversampling tick. It is the next-generation transmitter for the UART subsystem. It sits between the baud-rate tick generator and any byte source (FIFO, CPU register, bus bridge). Over the previous transmitter it adds:
- a valid/ready input with a one-entry holding buffer, giving gap-free back-to-back frames;
- selectable 1 / 1.5 / 2 stop bits;
- optional parity.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, legal 5..8.
- `OVS`, 16: `s_tick` pulses per bit period, even, legal 8..32.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `s_tick`  in  1  oversampling tick, one-cycle pulse.
- `tx_valid`  in  1  byte offered on `din`.
- `din`  in  8  byte; bits above `DBIT-1` are ignored.
- `tx_ready`  out  1  holding buffer empty; the byte is accepted when `tx_valid && tx_ready` at a rising edge.
- `stop_sel`  in  2  stop length: 00 = 1 bit, 01 = 1.5 bits, 10 or 11 = 2 bits.
- `par_mode`  in  2  parity: 00 or 11 = none, 01 = even, 10 = odd. Present only with `UART_TX_PARITY_EN`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress (state not IDLE).
- `tx_done_tick`  out  1  one-cycle pulse at the end of each frame.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP.
- Holding buffer: one byte plus a full flag; `tx_ready = ~full`. There is no bypass. An accept and a drain never happen on the same edge.
- IDLE: `tx` = 1. If the buffer is full, on the next edge:
  - go to START;
  - copy the buffer into the shift register;
  - latch `stop_sel` and `par_mode` (held for the whole frame);
  - clear the tick counter and clear `full`.
- Bit timing: the tick counter increments on `s_tick`. A START, DATA or PARITY bit ends on the edge where `s_tick` is high and the counter equals `OVS-1`. Without `s_tick` every register holds.
- START: `tx` = 0, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift register bit 0, sent LSB first.
  - At each bit end, shift right by one and increment the index.
  - After bit `DBIT-1`: go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: `tx` = XOR of the `DBIT` data bits for even parity, or its inverse for odd parity. Then go to STOP.
- STOP: `tx` = 1. Stop length is OVS, 3·OVS/2 or 2·OVS ticks, from the latched `stop_sel`. On the last stop tick:
  - pulse `tx_done_tick`;
  - if the buffer is full, go directly to START (load as in IDLE), giving zero idle time between frames;
  - otherwise go to IDLE.
- Tick counter width is `$clog2(2*OVS)`, wide enough for 2-stop-bit frames.
- Reset at any point, including mid-frame: on the next edge go to IDLE and discard the buffer and the frame in progress.

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, `tx_done_tick` = 0; all counters 0.
- `tx` is registered and decoded from the next state, so it changes on the same edge as the state register.
- Latency from idle: accept at edge E0, then state START, `tx` = 0 and `busy` = 1 at edge E1. `tx_ready` is 0 after E0 and returns to 1 after E1.
- Frame length in `s_tick` pulses: (1 + DBIT + P)·OVS + stop ticks, where P = 1 when parity is active.
- `tx_done_tick` is high for exactly one cycle, in the cycle after the final stop tick edge.
- `tx_valid` may be held high continuously; each accept consumes exactly one byte.

## Configuration
- `UART_TX_PARITY_EN` defined: the `par_mode` port and the PARITY state exist.
- `UART_TX_PARITY_EN` undefined:
  - the `par_mode` port is absent;
  - PARITY is never entered; DATA goes straight to STOP;
  - no parity logic is synthesised.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - the parity enum `uart_par_t` (NONE, EVEN, ODD);
  - the stop encoding `uart_stop_t`;
  - localparam encodings for `stop_sel` and `par_mode`.
- Sub-module `uart_tx_hold_buf` implements the one-entry valid/ready buffer (data register and full flag). All other logic lives in `uart_tx_cfg`.

## Test plan
- Single byte, DBIT=8, OVS=16, 1 stop bit, no parity: send 0x55. Expect `tx` low for 16 ticks, then bits 1,0,1,0,1,0,1,0 of 16 ticks each, then high for 16 ticks. `tx_done_tick` pulses once; `busy` falls.
- Back-to-back: hold `tx_valid` with 0xA3 then 0x0F. Expect the second start bit to begin on the edge after the first frame's last stop tick, with no idle gap, and 2 done pulses.
- Stop lengths: `stop_sel` = 01 and then 10, sending 0xFF. Expect stop lengths of 24 and 32 ticks. Change `stop_sel` mid-frame and expect no effect until the next frame.
- Parity (macro defined), DBIT=7: send 0x03. With even parity expect a parity bit of 0; with odd parity expect 1. Expect frame lengths of 10 bit periods.
- Reset mid-DATA with the buffer full: expect `tx` = 1, `tx_ready` = 1 and `busy` = 0 after one edge, and no `tx_done_tick`.
- `s_tick` withheld for 50 cycles mid-bit: expect `tx` and all state to hold, then resume with correct bit timing.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and encodings for the configurable UART transmitter.
// Parity support is controlled by the UART_TX_PARITY_EN macro in uart_tx_cfg.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } uart_par_t;

  typedef enum logic [1:0] {
    STOP_1,
    STOP_1P5,
    STOP_2
  } uart_stop_t;

  localparam logic [1:0] SEL_STOP_1    = 2'b00;
  localparam logic [1:0] SEL_STOP_1P5  = 2'b01;
  localparam logic [1:0] PAR_MODE_EVEN = 2'b01;
  localparam logic [1:0] PAR_MODE_ODD  = 2'b10;

  // stop_sel: 00 = 1 bit, 01 = 1.5 bits, 10/11 = 2 bits
  function automatic uart_stop_t decode_stop(input logic [1:0] sel);
    uart_stop_t s;
    case (sel)
      SEL_STOP_1:   s = STOP_1;
      SEL_STOP_1P5: s = STOP_1P5;
      default:      s = STOP_2;
    endcase
    return s;
  endfunction

  // par_mode: 01 = even, 10 = odd, 00/11 = none
  function automatic uart_par_t decode_par(input logic [1:0] mode);
    uart_par_t p;
    case (mode)
      PAR_MODE_EVEN: p = PAR_EVEN;
      PAR_MODE_ODD:  p = PAR_ODD;
      default:       p = PAR_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_hold_buf.sv
// One-entry valid/ready holding buffer feeding the UART transmitter.
// Accept and drain are mutually exclusive since accept needs the buffer empty.
module uart_tx_hold_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] din,
  input  logic         drain,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (drain) begin
      full <= 1'b0;
    end else if (valid && !full) begin
      full <= 1'b1;
      data <= din;
    end
  end

  assign ready = ~full;

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with holding buffer and 1/1.5/2 stop bits.
// Define UART_TX_PARITY_EN to add the par_mode port and the PARITY state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DBIT = 8,
  parameter int unsigned OVS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_valid,
  input  logic [7:0] din,
  output logic       tx_ready,
  input  logic [1:0] stop_sel,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0] par_mode,
`endif
  output logic       tx,
  output logic       busy,
  output logic       tx_done_tick
);

  localparam int unsigned CW = $clog2(2 * OVS);
  localparam int unsigned BW = $clog2(DBIT);

  localparam logic [CW-1:0] BIT_LAST    = CW'(OVS - 1);
  localparam logic [CW-1:0] STOP15_LAST = CW'((3 * OVS) / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OVS - 1);
  localparam logic [BW-1:0] IDX_LAST    = BW'(DBIT - 1);

  uart_tx_state_t  state_q, state_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  uart_stop_t      stop_q, stop_d;
`ifdef UART_TX_PARITY_EN
  logic            par_on_q, par_on_d;
  logic            par_bit_q, par_bit_d;
  uart_par_t       par_sel;
`endif

  logic            tx_d, busy_d, done_d;
  logic            load, frame_end;
  logic            bit_end;
  logic [CW-1:0]   stop_last;

  logic            buf_ready, buf_full;
  logic [DBIT-1:0] buf_data;

  uart_tx_hold_buf #(.W(DBIT)) u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .valid (tx_valid),
    .din   (din[DBIT-1:0]),
    .drain (load),
    .ready (buf_ready),
    .full  (buf_full),
    .data  (buf_data)
  );

  assign tx_ready = buf_ready;
  assign bit_end  = s_tick && (tick_q == BIT_LAST);
  assign stop_last = (stop_q == STOP_1)   ? BIT_LAST :
                     (stop_q == STOP_1P5) ? STOP15_LAST : STOP2_LAST;

`ifdef UART_TX_PARITY_EN
  assign par_sel = decode_par(par_mode);
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      stop_q       <= STOP_1;
`ifdef UART_TX_PARITY_EN
      par_on_q     <= 1'b0;
      par_bit_q    <= 1'b0;
`endif
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      stop_q       <= stop_d;
`ifdef UART_TX_PARITY_EN
      par_on_q     <= par_on_d;
      par_bit_q    <= par_bit_d;
`endif
      tx           <= tx_d;
      busy         <= busy_d;
      tx_done_tick <= done_d;
    end
  end

  // Next state and datapath; nothing advances without s_tick except a load
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    stop_d    = stop_q;
`ifdef UART_TX_PARITY_EN
    par_on_d  = par_on_q;
    par_bit_d = par_bit_q;
`endif
    load      = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load = buf_full;
      end
      ST_START: begin
        if (bit_end) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_on_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = ST_STOP;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == stop_last) begin
            frame_end = 1'b1;
            tick_d    = '0;
            state_d   = ST_IDLE;
            load      = buf_full;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame configuration is captured here and held until the next load
    if (load) begin
      state_d   = ST_START;
      tick_d    = '0;
      idx_d     = '0;
      shreg_d   = buf_data;
      stop_d    = decode_stop(stop_sel);
`ifdef UART_TX_PARITY_EN
      par_on_d  = (par_sel != PAR_NONE);
      par_bit_d = (^buf_data) ^ (par_sel == PAR_ODD);
`endif
    end
  end

  // Line level decoded from the next state so tx moves with the state register
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = frame_end;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_bit_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of single frames plus hand-written corner sequences.
// The DBIT=7 parity instance is only built when UART_TX_PARITY_EN is defined.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] stop_sel = 2'b00;
  logic       tx, tx_ready, busy, tx_done_tick;
  logic       tx7, ready7, busy7, done7;
  logic       use7 = 1'b0;
  logic       tick_en = 1'b0;
  logic       ph = 1'b0;
  logic       mon_tx, mon_ready, mon_busy, mon_done;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
`ifdef UART_TX_PARITY_EN
  logic [1:0] par_mode = 2'b00;
`endif

  always #5 clk = ~clk;

  // s_tick every other cycle while enabled, updated away from the rising edge
  always @(negedge clk) begin
    s_tick = tick_en & ph;
    ph     = ~ph;
  end

  uart_tx_cfg #(.DBIT(8), .OVS(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_valid     (tx_valid & ~use7),
    .din          (din),
    .tx_ready     (tx_ready),
    .stop_sel     (stop_sel),
`ifdef UART_TX_PARITY_EN
    .par_mode     (2'b00),
`endif
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_cfg #(.DBIT(7), .OVS(16)) u_dut7 (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_valid     (tx_valid & use7),
    .din          (din),
    .tx_ready     (ready7),
    .stop_sel     (stop_sel),
    .par_mode     (par_mode),
    .tx           (tx7),
    .busy         (busy7),
    .tx_done_tick (done7)
  );
`else
  assign tx7    = 1'b1;
  assign ready7 = 1'b1;
  assign busy7  = 1'b0;
  assign done7  = 1'b0;
`endif

  assign mon_tx    = use7 ? tx7    : tx;
  assign mon_ready = use7 ? ready7 : tx_ready;
  assign mon_busy  = use7 ? busy7  : busy;
  assign mon_done  = use7 ? done7  : tx_done_tick;

  always @(negedge clk) if (mon_done) done_cnt++;

  typedef struct {
    logic [7:0] d;
    logic [1:0] ss;
    int         stop_t;
  } vec_t;

  vec_t vt [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic checkn(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // tx must sit at lvl for every cycle spanning n s_tick edges
  task automatic seg(input string nm, input logic lvl, input int n);
    logic got;
    logic tk;
    int   guard;
    got = lvl;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      tk    = 1'b0;
      do begin
        if (mon_tx !== lvl && got === lvl) got = mon_tx;
        @(posedge clk);
        tk = s_tick;
        #1;
        guard++;
      end while (!tk && guard < 100);
      if (!tk) got = ~lvl;
    end
    check1(nm, got, lvl);
  endtask

  task automatic frame(input string nm, input logic [7:0] d, input int nb,
                       input logic par_on, input logic par_val, input int stop_t);
    seg({nm, ".start"}, 1'b0, 16);
    for (int i = 0; i < nb; i++) seg($sformatf("%s.d%0d", nm, i), d[i], 16);
    if (par_on) seg({nm, ".par"}, par_val, 16);
    seg({nm, ".stop"}, 1'b1, stop_t);
  endtask

  // Offer one byte from idle with ticks paused and check the two-edge latency
  task automatic launch(input string nm, input logic [7:0] d);
    tick_en  = 1'b0;
    tx_valid = 1'b1;
    din      = d;
    step();
    tx_valid = 1'b0;
    check1({nm, ".ready_acc"}, mon_ready, 1'b0);
    check1({nm, ".tx_idle_e0"}, mon_tx, 1'b1);
    step();
    check1({nm, ".tx_start"}, mon_tx, 1'b0);
    check1({nm, ".busy_start"}, mon_busy, 1'b1);
    check1({nm, ".ready_load"}, mon_ready, 1'b1);
    tick_en = 1'b1;
  endtask

  task automatic finish_idle(input string nm, input int c0, input int ndone);
    check1({nm, ".done"}, mon_done, 1'b1);
    check1({nm, ".busy_end"}, mon_busy, 1'b0);
    check1({nm, ".tx_end"}, mon_tx, 1'b1);
    step();
    check1({nm, ".done_low"}, mon_done, 1'b0);
    checkn({nm, ".done_cnt"}, done_cnt - c0, ndone);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    logic hold_ok;

    vt[0] = '{8'h55, 2'b00, 16};
    vt[1] = '{8'hFF, 2'b01, 24};
    vt[2] = '{8'hFF, 2'b10, 32};
    vt[3] = '{8'h00, 2'b11, 32};
    vt[4] = '{8'h81, 2'b00, 16};

    // Reset state
    rst = 1'b1;
    step();
    step();
    check1("rst.tx", mon_tx, 1'b1);
    check1("rst.ready", mon_ready, 1'b1);
    check1("rst.busy", mon_busy, 1'b0);
    check1("rst.done", mon_done, 1'b0);
    rst = 1'b0;
    step();
    check1("post_rst.tx", mon_tx, 1'b1);
    check1("post_rst.busy", mon_busy, 1'b0);

    // Single frames with different data and stop lengths
    for (int k = 0; k < 5; k++) begin
      stop_sel = vt[k].ss;
      c0 = done_cnt;
      launch($sformatf("v%0d", k), vt[k].d);
      frame($sformatf("v%0d", k), vt[k].d, 8, 1'b0, 1'b0, vt[k].stop_t);
      finish_idle($sformatf("v%0d", k), c0, 1);
    end

    // Back-to-back frames with tx_valid held: no idle gap between frames
    stop_sel = 2'b00;
    c0 = done_cnt;
    tick_en  = 1'b0;
    tx_valid = 1'b1;
    din      = 8'hA3;
    step();
    din = 8'h0F;
    check1("b2b.ready_acc", mon_ready, 1'b0);
    step();
    check1("b2b.tx_start", mon_tx, 1'b0);
    check1("b2b.ready_load", mon_ready, 1'b1);
    step();
    tx_valid = 1'b0;
    check1("b2b.ready_full", mon_ready, 1'b0);
    tick_en = 1'b1;
    frame("b2b0", 8'hA3, 8, 1'b0, 1'b0, 16);
    check1("b2b.gapless_tx", mon_tx, 1'b0);
    check1("b2b.mid_done", mon_done, 1'b1);
    check1("b2b.mid_busy", mon_busy, 1'b1);
    check1("b2b.mid_ready", mon_ready, 1'b1);
    frame("b2b1", 8'h0F, 8, 1'b0, 1'b0, 16);
    finish_idle("b2b", c0, 2);

    // stop_sel changed mid-frame only affects later frames
    stop_sel = 2'b00;
    c0 = done_cnt;
    launch("sc", 8'hFF);
    stop_sel = 2'b10;
    frame("sc", 8'hFF, 8, 1'b0, 1'b0, 16);
    finish_idle("sc", c0, 1);
    stop_sel = 2'b00;

    // s_tick withheld mid-bit for 50 cycles
    c0 = done_cnt;
    launch("hold", 8'h55);
    seg("hold.start", 1'b0, 16);
    seg("hold.d0a", 1'b1, 8);
    tick_en = 1'b0;
    hold_ok = 1'b1;
    repeat (50) begin
      if (mon_tx !== 1'b1 || mon_busy !== 1'b1) hold_ok = 1'b0;
      step();
    end
    check1("hold.frozen", hold_ok, 1'b1);
    tick_en = 1'b1;
    seg("hold.d0b", 1'b1, 8);
    for (int i = 1; i < 8; i++) seg($sformatf("hold.d%0d", i), i[0] ? 1'b0 : 1'b1, 16);
    seg("hold.stop", 1'b1, 16);
    finish_idle("hold", c0, 1);

    // Reset mid-DATA with the buffer full discards both bytes
    tick_en  = 1'b0;
    tx_valid = 1'b1;
    din      = 8'h55;
    step();
    din = 8'hC3;
    step();
    step();
    tx_valid = 1'b0;
    check1("rmid.ready_full", mon_ready, 1'b0);
    tick_en = 1'b1;
    seg("rmid.start", 1'b0, 16);
    seg("rmid.d0", 1'b1, 16);
    seg("rmid.d1", 1'b0, 4);
    c0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("rmid.tx", mon_tx, 1'b1);
    check1("rmid.ready", mon_ready, 1'b1);
    check1("rmid.busy", mon_busy, 1'b0);
    check1("rmid.done", mon_done, 1'b0);
    repeat (200) step();
    check1("rmid.tx_later", mon_tx, 1'b1);
    check1("rmid.busy_later", mon_busy, 1'b0);
    checkn("rmid.done_cnt", done_cnt - c0, 0);

`ifdef UART_TX_PARITY_EN
    // DBIT=7 parity frames: 0x03 and 0x83 share the same 7 data bits
    use7 = 1'b1;
    step();
    par_mode = 2'b01;
    c0 = done_cnt;
    launch("pe", 8'h03);
    frame("pe", 8'h03, 7, 1'b1, 1'b0, 16);
    finish_idle("pe", c0, 1);
    par_mode = 2'b10;
    c0 = done_cnt;
    launch("po", 8'h83);
    frame("po", 8'h83, 7, 1'b1, 1'b1, 16);
    finish_idle("po", c0, 1);
    par_mode = 2'b11;
    c0 = done_cnt;
    launch("pn", 8'h03);
    frame("pn", 8'h03, 7, 1'b0, 1'b0, 16);
    finish_idle("pn", c0, 1);
    use7 = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
